// File: rtl/VX_gpu_pkg.sv
// Shared GPU definitions used by the global-barrier requester and responder.
// Field widths are fixed here so both sides of the gbar link agree on them.
// The core id field is one bit wider than the core count needs, so an out-of-range sender can be encoded.
package VX_gpu_pkg;

  localparam int GBAR_MAX_CORES    = 4;
  localparam int GBAR_MAX_BARRIERS = 8;

  localparam int NB_WIDTH = $clog2(GBAR_MAX_BARRIERS);
  localparam int NC_WIDTH = $clog2(GBAR_MAX_CORES + 1);

  typedef struct packed {
    logic [NB_WIDTH-1:0] id;
    logic [NC_WIDTH-1:0] size_m1;
    logic [NC_WIDTH-1:0] core_id;
  } gbar_req_t;

  typedef struct packed {
    logic [NB_WIDTH-1:0] id;
  } gbar_rsp_t;

endpackage

// File: rtl/VX_rr_arbiter.sv
// Round-robin arbiter: picks the first active request at or after the pointer.
// Latency: combinational grant; the pointer updates on the clock edge of an accepted grant.
// Backpressure: the pointer holds while grant_ready is low or nothing is requested.
module VX_rr_arbiter #(
  parameter int NUM_REQS = 4,
  localparam int LOG_NUM_REQS = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_REQS-1:0]     requests,
  input  logic                    grant_ready,
  output logic [LOG_NUM_REQS-1:0] grant_index,
  output logic [NUM_REQS-1:0]     grant_onehot,
  output logic                    grant_valid
);

  logic [LOG_NUM_REQS-1:0] ptr_q;

  // Search from the pointer up to the top, then wrap around to index 0.
  always_comb begin
    grant_index  = '0;
    grant_onehot = '0;
    grant_valid  = 1'b0;
    for (int i = 0; i < NUM_REQS; i++) begin
      if (!grant_valid && requests[i] && (i >= int'(ptr_q))) begin
        grant_valid     = 1'b1;
        grant_index     = LOG_NUM_REQS'(i);
        grant_onehot[i] = 1'b1;
      end
    end
    for (int i = 0; i < NUM_REQS; i++) begin
      if (!grant_valid && requests[i]) begin
        grant_valid     = 1'b1;
        grant_index     = LOG_NUM_REQS'(i);
        grant_onehot[i] = 1'b1;
      end
    end
  end

  // Move the pointer to one past the winner after each accepted grant.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= '0;
    end else if (grant_valid && grant_ready) begin
      ptr_q <= (grant_index == LOG_NUM_REQS'(NUM_REQS - 1)) ? '0 : grant_index + 1'b1;
    end
  end

endmodule

// File: rtl/vx_gbar_responder.sv
// Global barrier responder: collects per-core arrivals per barrier id and broadcasts a release.
// Latency: 1 cycle from the completing accept to rsp_valid (2 cycles with OUT_REG=1).
// Backpressure: one request accepted per cycle through round-robin; rsp has no backpressure.
module vx_gbar_responder
  import VX_gpu_pkg::*;
#(
  parameter int NUM_REQS     = 4,
  parameter int NUM_BARRIERS = 8,
  parameter int OUT_REG      = 0
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_REQS-1:0]                req_valid,
  input  logic [NUM_REQS-1:0][NB_WIDTH-1:0]  req_id,
  input  logic [NUM_REQS-1:0][NC_WIDTH-1:0]  req_size_m1,
  input  logic [NUM_REQS-1:0][NC_WIDTH-1:0]  req_core_id,
  output logic [NUM_REQS-1:0]                req_ready,
  output logic                               rsp_valid,
  output logic [NB_WIDTH-1:0]                rsp_id,
  output logic                               err_dup,
  output logic                               err_size,
  output logic                               busy
);

  localparam int LOG_REQS = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;
  localparam int CNT_W    = $clog2(NUM_REQS + 1);

  logic [LOG_REQS-1:0] grant_idx;
  logic [NUM_REQS-1:0] grant_oh;
  logic                grant_vld;

  VX_rr_arbiter #(.NUM_REQS(NUM_REQS)) arb (
    .clk          (clk),
    .reset        (reset),
    .requests     (req_valid),
    .grant_ready  (1'b1),
    .grant_index  (grant_idx),
    .grant_onehot (grant_oh),
    .grant_valid  (grant_vld)
  );

  assign req_ready = grant_oh;

  logic [NUM_BARRIERS-1:0][NUM_REQS-1:0] mask_q;
  logic [NUM_BARRIERS-1:0][NC_WIDTH-1:0] size_q;

  gbar_req_t           sel_req;
  logic [NUM_REQS-1:0] cur_mask;
  logic [NUM_REQS-1:0] core_oh;
  logic [CNT_W-1:0]    cur_cnt;
  logic [NC_WIDTH-1:0] eff_size;
  logic                bad_core, dup_hit, size_mis, do_release, do_set;

  // Decode the granted request against the current state of its barrier.
  always_comb begin
    sel_req.id      = req_id[grant_idx];
    sel_req.size_m1 = req_size_m1[grant_idx];
    sel_req.core_id = req_core_id[grant_idx];
    cur_mask        = mask_q[sel_req.id];
    core_oh         = '0;
    cur_cnt         = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      core_oh[i] = (int'(sel_req.core_id) == i);
      cur_cnt    = cur_cnt + CNT_W'(cur_mask[i]);
    end
    bad_core   = (int'(sel_req.core_id) >= NUM_REQS);
    dup_hit    = |(cur_mask & core_oh);
    // A barrier in progress keeps the size latched by its first arrival.
    eff_size   = (cur_mask == '0) ? sel_req.size_m1 : size_q[sel_req.id];
    size_mis   = (cur_mask != '0) && (sel_req.size_m1 != size_q[sel_req.id]);
    do_release = grant_vld && !bad_core && !dup_hit && (int'(cur_cnt) == int'(eff_size));
    do_set     = grant_vld && !bad_core && !dup_hit && !do_release;
  end

  // Arrival masks and latched sizes; a release returns the id to an empty epoch.
  always_ff @(posedge clk) begin
    if (reset) begin
      mask_q <= '0;
      size_q <= '0;
    end else if (do_release) begin
      mask_q[sel_req.id] <= '0;
    end else if (do_set) begin
      mask_q[sel_req.id] <= cur_mask | core_oh;
      if (cur_mask == '0) begin
        size_q[sel_req.id] <= sel_req.size_m1;
      end
    end
  end

  logic      rsp_vld_s1, dup_s1, size_s1;
  gbar_rsp_t rsp_s1;

  // First response stage: release and error pulses one cycle after the accept.
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_vld_s1 <= 1'b0;
      rsp_s1     <= '0;
      dup_s1     <= 1'b0;
      size_s1    <= 1'b0;
    end else begin
      rsp_vld_s1 <= do_release;
      rsp_s1.id  <= do_release ? sel_req.id : '0;
      dup_s1     <= grant_vld && (bad_core || dup_hit);
      size_s1    <= grant_vld && !bad_core && !dup_hit && size_mis;
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic      rsp_vld_s2, dup_s2, size_s2;
      gbar_rsp_t rsp_s2;
      // Optional extra output stage for timing closure toward the cores.
      always_ff @(posedge clk) begin
        if (reset) begin
          rsp_vld_s2 <= 1'b0;
          rsp_s2     <= '0;
          dup_s2     <= 1'b0;
          size_s2    <= 1'b0;
        end else begin
          rsp_vld_s2 <= rsp_vld_s1;
          rsp_s2     <= rsp_s1;
          dup_s2     <= dup_s1;
          size_s2    <= size_s1;
        end
      end
      assign rsp_valid = rsp_vld_s2;
      assign rsp_id    = rsp_s2.id;
      assign err_dup   = dup_s2;
      assign err_size  = size_s2;
    end else begin : g_no_out_reg
      assign rsp_valid = rsp_vld_s1;
      assign rsp_id    = rsp_s1.id;
      assign err_dup   = dup_s1;
      assign err_size  = size_s1;
    end
  endgenerate

  // Busy while any barrier has at least one core waiting.
  always_comb begin
    busy = |mask_q;
  end

endmodule

// File: tb/tb_vx_gbar_responder.sv
// Directed bench for the global barrier responder with four cores and eight ids.
// Each task drives one scenario and compares outputs one cycle after the accept edge.
// Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
module tb_vx_gbar_responder;
  import VX_gpu_pkg::*;

  logic                         clk = 1'b0;
  logic                         reset;
  logic [3:0]                   req_valid;
  logic [3:0][NB_WIDTH-1:0]     req_id;
  logic [3:0][NC_WIDTH-1:0]     req_size_m1;
  logic [3:0][NC_WIDTH-1:0]     req_core_id;
  logic [3:0]                   req_ready;
  logic                         rsp_valid;
  logic [NB_WIDTH-1:0]          rsp_id;
  logic                         err_dup;
  logic                         err_size;
  logic                         busy;

  int n_cmp = 0;
  int n_bad = 0;

  vx_gbar_responder #(.NUM_REQS(4), .NUM_BARRIERS(8), .OUT_REG(0)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_id      (req_id),
    .req_size_m1 (req_size_m1),
    .req_core_id (req_core_id),
    .req_ready   (req_ready),
    .rsp_valid   (rsp_valid),
    .rsp_id      (rsp_id),
    .err_dup     (err_dup),
    .err_size    (err_size),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // One request from lane `lane`, held for exactly one rising edge.
  task automatic send(input int lane, input int id, input int sz, input int cid);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      req_id[i]      = NB_WIDTH'(id);
      req_size_m1[i] = NC_WIDTH'(sz);
      req_core_id[i] = NC_WIDTH'(cid);
    end
    req_valid = 4'(1) << lane;
    @(posedge clk);
    #1;
    req_valid = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req_valid = '0;
    req_id = '0;
    req_size_m1 = '0;
    req_core_id = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rsp_valid got=%b want=0", rsp_valid); end
    n_cmp++; if (rsp_id !== 3'd0) begin n_bad++; $display("FAIL reset_rsp_id got=%0d want=0", rsp_id); end
    n_cmp++; if (err_dup !== 1'b0) begin n_bad++; $display("FAIL reset_err_dup got=%b want=0", err_dup); end
    n_cmp++; if (err_size !== 1'b0) begin n_bad++; $display("FAIL reset_err_size got=%b want=0", err_size); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    n_cmp++; if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL reset_req_ready got=%b want=0000", req_ready); end
  endtask

  // Cores 0..3 arrive one per cycle on id 2 with size_m1=3.
  task automatic test_sequential();
    for (int c = 0; c < 3; c++) begin
      send(c, 2, 3, c);
      n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL seq_early_rsp core=%0d got=%b want=0", c, rsp_valid); end
      n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL seq_busy core=%0d got=%b want=1", c, busy); end
    end
    send(3, 2, 3, 3);
    n_cmp++; if (rsp_valid !== 1'b1) begin n_bad++; $display("FAIL seq_rsp_valid got=%b want=1", rsp_valid); end
    n_cmp++; if (rsp_id !== 3'd2) begin n_bad++; $display("FAIL seq_rsp_id got=%0d want=2", rsp_id); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL seq_busy_after got=%b want=0", busy); end
    @(posedge clk);
    #1;
    n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL seq_rsp_one_cycle got=%b want=0", rsp_valid); end
  endtask

  // All four cores request id 1 together; each drops its valid once granted.
  task automatic test_all_same_cycle();
    logic [3:0] pending;
    logic [3:0] exp_rdy;
    pending = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      req_id[i]      = NB_WIDTH'(1);
      req_size_m1[i] = NC_WIDTH'(3);
      req_core_id[i] = NC_WIDTH'(i);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      req_valid = pending;
      #1;
      exp_rdy = 4'(1) << k;
      n_cmp++; if (req_ready !== exp_rdy) begin n_bad++; $display("FAIL rr_grant step=%0d got=%b want=%b", k, req_ready, exp_rdy); end
      @(posedge clk);
      #1;
      pending = pending & ~exp_rdy;
      req_valid = pending;
      n_cmp++; if (rsp_valid !== (k == 3)) begin n_bad++; $display("FAIL rr_rsp step=%0d got=%b want=%b", k, rsp_valid, (k == 3)); end
    end
    n_cmp++; if (rsp_id !== 3'd1) begin n_bad++; $display("FAIL rr_rsp_id got=%0d want=1", rsp_id); end
    req_valid = '0;
  endtask

  // size_m1=0 releases on the first arrival and leaves no mask bit behind.
  task automatic test_size_zero();
    send(2, 5, 0, 2);
    n_cmp++; if (rsp_valid !== 1'b1) begin n_bad++; $display("FAIL sz0_rsp_valid got=%b want=1", rsp_valid); end
    n_cmp++; if (rsp_id !== 3'd5) begin n_bad++; $display("FAIL sz0_rsp_id got=%0d want=5", rsp_id); end
    n_cmp++; if (dut.mask_q[5] !== 4'b0000) begin n_bad++; $display("FAIL sz0_mask got=%b want=0000", dut.mask_q[5]); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL sz0_busy got=%b want=0", busy); end
  endtask

  // Duplicate arrival from core 1, then a size mismatch that must use the latched size.
  task automatic test_dup_and_size();
    send(1, 0, 3, 1);
    n_cmp++; if (err_dup !== 1'b0) begin n_bad++; $display("FAIL dup_first got=%b want=0", err_dup); end
    send(1, 0, 3, 1);
    n_cmp++; if (err_dup !== 1'b1) begin n_bad++; $display("FAIL dup_pulse got=%b want=1", err_dup); end
    n_cmp++; if (dut.mask_q[0] !== 4'b0010) begin n_bad++; $display("FAIL dup_mask got=%b want=0010", dut.mask_q[0]); end
    send(0, 0, 2, 0);
    n_cmp++; if (err_dup !== 1'b0) begin n_bad++; $display("FAIL dup_cleared got=%b want=0", err_dup); end
    n_cmp++; if (err_size !== 1'b1) begin n_bad++; $display("FAIL size_pulse got=%b want=1", err_size); end
    send(2, 0, 3, 2);
    n_cmp++; if (err_size !== 1'b0) begin n_bad++; $display("FAIL size_cleared got=%b want=0", err_size); end
    n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL size_latched_early got=%b want=0", rsp_valid); end
    send(3, 0, 3, 3);
    n_cmp++; if (rsp_valid !== 1'b1 || rsp_id !== 3'd0) begin n_bad++; $display("FAIL size_release got=%b/%0d want=1/0", rsp_valid, rsp_id); end
  endtask

  // An out-of-range core id is dropped even though size_m1=0 would release.
  task automatic test_bad_core();
    send(0, 7, 0, 5);
    n_cmp++; if (err_dup !== 1'b1) begin n_bad++; $display("FAIL badcore_err got=%b want=1", err_dup); end
    n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL badcore_rsp got=%b want=0", rsp_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL badcore_busy got=%b want=0", busy); end
  endtask

  // Interleaved ids 3 and 4, two cores each.
  task automatic test_interleave();
    send(0, 3, 1, 0);
    send(1, 4, 1, 1);
    n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL il_early got=%b want=0", rsp_valid); end
    send(2, 3, 1, 2);
    n_cmp++; if (rsp_valid !== 1'b1 || rsp_id !== 3'd3) begin n_bad++; $display("FAIL il_rel3 got=%b/%0d want=1/3", rsp_valid, rsp_id); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL il_busy got=%b want=1", busy); end
    send(3, 4, 1, 3);
    n_cmp++; if (rsp_valid !== 1'b1 || rsp_id !== 3'd4) begin n_bad++; $display("FAIL il_rel4 got=%b/%0d want=1/4", rsp_valid, rsp_id); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL il_idle got=%b want=0", busy); end
  endtask

  // An arrival on the cycle right after a release starts a fresh epoch.
  task automatic test_back_to_back();
    send(0, 2, 1, 0);
    send(1, 2, 1, 1);
    n_cmp++; if (rsp_valid !== 1'b1) begin n_bad++; $display("FAIL b2b_rel1 got=%b want=1", rsp_valid); end
    send(2, 2, 1, 2);
    n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_new_epoch got=%b want=0", rsp_valid); end
    n_cmp++; if (dut.mask_q[2] !== 4'b0100) begin n_bad++; $display("FAIL b2b_mask got=%b want=0100", dut.mask_q[2]); end
    send(3, 2, 1, 3);
    n_cmp++; if (rsp_valid !== 1'b1 || rsp_id !== 3'd2) begin n_bad++; $display("FAIL b2b_rel2 got=%b/%0d want=1/2", rsp_valid, rsp_id); end
  endtask

  // Reset with id 6 half-filled drops it silently; id 6 then works normally.
  task automatic test_reset_mid();
    send(0, 6, 3, 0);
    send(1, 6, 3, 1);
    n_cmp++; if (dut.mask_q[6] !== 4'b0011) begin n_bad++; $display("FAIL rmid_mask got=%b want=0011", dut.mask_q[6]); end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rmid_busy got=%b want=0", busy); end
    n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL rmid_rsp got=%b want=0", rsp_valid); end
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL rmid_rsp_after got=%b want=0", rsp_valid); end
    send(0, 6, 1, 0);
    n_cmp++; if (rsp_valid !== 1'b0 || busy !== 1'b1) begin n_bad++; $display("FAIL rmid_first got=%b/%b want=0/1", rsp_valid, busy); end
    send(1, 6, 1, 1);
    n_cmp++; if (rsp_valid !== 1'b1 || rsp_id !== 3'd6) begin n_bad++; $display("FAIL rmid_release got=%b/%0d want=1/6", rsp_valid, rsp_id); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_all_same_cycle();
    test_size_zero();
    test_dup_and_size();
    test_bad_core();
    test_interleave();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vx_gbar_responder.md
VX_GBAR_RESPONDER -- requirements
Module: vx_gbar_responder

Interface
REQ-001 SHALL have parameter NUM_REQS, default 4, number of cores (requesters) sharing the global barrier.
REQ-002 SHALL have parameter NUM_BARRIERS, default 8, number of global barrier ids.
REQ-003 SHALL have parameter OUT_REG, default 0: 0 gives a 1-cycle response latency; 1 adds one output register stage (2-cycle latency).
REQ-004 SHALL have port clk, input, 1, clock.
REQ-005 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have port req_valid, input, NUM_REQS, per-core barrier-arrival request.
REQ-007 SHALL have port req_id, input, NUM_REQS x NB_WIDTH, barrier id per core.
REQ-008 SHALL have port req_size_m1, input, NUM_REQS x NC_WIDTH, participating core count minus one.
REQ-009 SHALL have port req_core_id, input, NUM_REQS x NC_WIDTH, sender core id.
REQ-010 SHALL have port req_ready, output, NUM_REQS, per-core accept; one-hot or zero.
REQ-011 SHALL have port rsp_valid, output, 1, release pulse broadcast to all cores.
REQ-012 SHALL have port rsp_id, output, NB_WIDTH, id of the released barrier.
REQ-013 SHALL have port err_dup, output, 1, one-cycle pulse on a duplicate arrival.
REQ-014 SHALL have port err_size, output, 1, one-cycle pulse on a size_m1 mismatch.
REQ-015 SHALL have port busy, output, 1, high while any barrier holds a nonzero arrival mask.

Function
REQ-016 SHALL accept at most one request per cycle, using a round-robin arbiter over req_valid; an accept is req_valid[i] && req_ready[i].
REQ-017 SHALL advance the round-robin pointer to grant_index+1 (mod NUM_REQS) after each accept, and hold it when there is no accept.
REQ-018 SHALL keep, per barrier id, a NUM_REQS-bit arrival mask and a latched size_m1.
REQ-019 SHALL, on an accept where the popcount of mask[id] before the accept equals size_m1, clear mask[id] and issue rsp_valid=1, rsp_id=id exactly one cycle later (OUT_REG=0).
REQ-020 SHALL otherwise, on an accept, set mask[id][req_core_id]; if the mask was zero, it SHALL also latch size_m1.
REQ-021 SHALL release on the first arrival when size_m1==0, without setting any mask bit.
REQ-022 SHALL, on an accept whose mask[id][req_core_id] is already set, leave the state unchanged and pulse err_dup the next cycle.
REQ-023 SHALL, on an accept whose size_m1 differs from the latched nonzero-mask value, use the latched value and pulse err_size the next cycle.
REQ-024 SHALL drop any req_core_id >= NUM_REQS, assert no response, and pulse err_dup.
REQ-025 SHALL hold rsp_valid for exactly one cycle per release; there is no backpressure on rsp.
REQ-026 SHALL count an arrival for the same id in the cycle after a release toward a new epoch starting from an empty mask.
REQ-027 SHALL compare popcounts at CLOG2(NUM_REQS+1) bits, zero-extended against size_m1.
REQ-028 SHALL compute busy combinationally as the OR of all masks.

Reset
REQ-029 SHALL, on reset, clear all masks, latched sizes, the arbiter pointer (to 0), rsp_valid, err_dup, err_size, and the output register; rsp_id SHALL be 0.
REQ-030 SHALL drop any in-flight arrivals when reset is asserted mid-operation, with no release emitted.

Structure
REQ-031 SHALL take NB_WIDTH, NC_WIDTH and the gbar request/response field definitions from VX_gpu_pkg, shared with the core-side requester.
REQ-032 SHALL instantiate the existing VX_rr_arbiter as its single sub-module for request selection.

Verification
REQ-033 SHALL cover: NUM_REQS=4; cores 0..3 each send id=2, size_m1=3 on separate cycles -> one rsp_valid with rsp_id=2 one cycle after core 3's accept, and busy returns to 0.
REQ-034 SHALL cover: all four cores assert req_valid in the same cycle, id=1 -> grants in order 0,1,2,3 on four consecutive cycles, and a release after the fourth.
REQ-035 SHALL cover: size_m1=0 from core 2, id=5 -> rsp_valid, rsp_id=5 next cycle, and mask[5] stays 0.
REQ-036 SHALL cover: core 1 sends id=0 twice with size_m1=3 -> err_dup pulse on the second, with mask popcount still 1.
REQ-037 SHALL cover: interleaved ids 3 and 4 with size_m1=1 -> two independent releases, each within 1 cycle of its completing accept.
REQ-038 SHALL cover: reset asserted with mask[6]=0b0011 -> no rsp, busy=0, and a later 2-core sequence on id 6 releases normally.
